sync_fifo_gen2: RTL and testbench

Parametrised single-clock FIFO succeeding the team's fixed-geometry FIFO: arbitrary width and depth (including non-power-of-two), programmable almost-full/almost-empty thresholds, live fill level, per-cycle and sticky error flags, and a soft flush. It sits between a producer and a consumer in the same clock domain, as the standard buffering stage for the verification environment's DUTs.

---
 rtl/sync_fifo_gen2_pkg.sv | 24 ++
 rtl/sync_fifo_gen2_if.sv | 39 +++
 rtl/sync_fifo_gen2_wrap_ptr.sv | 28 ++
 rtl/sync_fifo_gen2.sv | 146 ++++++++++++++
 tb/tb_sync_fifo_gen2.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_gen2_pkg.sv
// rtl/sync_fifo_gen2_pkg.sv - shared types, defaults and width helpers for sync_fifo_gen2
package sync_fifo_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_AE_LEVEL = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
  } fifo_status_t;

  // Fill level must represent 0..DEPTH inclusive, hence depth+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_gen2_if.sv
// rtl/sync_fifo_gen2_if.sv - producer/consumer bundle of sync_fifo_gen2 (data, handshake, status)
interface sync_fifo_gen2_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  import sync_fifo_pkg::*;

  localparam int CW = cnt_width(DEPTH);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             wr_ack;
  logic             overflow;
  logic             underflow;
  logic             ovf_sticky;
  logic             udf_sticky;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almostfull;
  logic             almostempty;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
           ovf_sticky, udf_sticky, count, full, empty, almostfull, almostempty
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, rd_valid, wr_ack, overflow, underflow,
           ovf_sticky, udf_sticky, count, full, empty, almostfull, almostempty
  );

endinterface

// File: rtl/sync_fifo_gen2_wrap_ptr.sv
// rtl/sync_fifo_gen2_wrap_ptr.sv - modulo-DEPTH pointer that wraps by explicit compare
module fifo_wrap_ptr
  import sync_fifo_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // Compare against DEPTH-1 so non-power-of-two depths wrap correctly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo_gen2.sv
// rtl/sync_fifo_gen2.sv - parametrised single-clock FIFO; SYNC_FIFO_FWFT_EN selects first-word-fall-through
module sync_fifo_gen2
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_gen2_if.slave bus
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_gen2: DEPTH must be at least 2");
  end
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $error("sync_fifo_gen2: thresholds need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_acc;
  logic             rd_acc;
  logic             wr_ack_q;
  logic             ovf_q;
  logic             udf_q;
  logic             ovf_st;
  logic             udf_st;
  logic [WIDTH-1:0] data_q;
  logic             rd_valid_q;
  fifo_status_t     status;

  // A full FIFO still accepts a write when the same cycle also pops a word.
  always_comb begin
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    if (!bus.flush) begin
      rd_acc = bus.rd_en && (count != '0);
      wr_acc = bus.wr_en && ((count != DEPTH_C) || rd_acc);
    end
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .inc (rd_acc),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      ovf_st   <= 1'b0;
      udf_st   <= 1'b0;
    end else if (bus.flush) begin
      count    <= '0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      ovf_st   <= 1'b0;
      udf_st   <= 1'b0;
    end else begin
      count    <= count + CW'(wr_acc) - CW'(rd_acc);
      wr_ack_q <= wr_acc;
      ovf_q    <= bus.wr_en && !wr_acc;
      udf_q    <= bus.rd_en && !rd_acc;
      if (bus.wr_en && !wr_acc) begin
        ovf_st <= 1'b1;
      end
      if (bus.rd_en && !rd_acc) begin
        udf_st <= 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown directly; zero while empty keeps data_out defined.
  assign data_q     = (count == '0) ? '0 : mem[rd_ptr];
  assign rd_valid_q = (count != '0);
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      rd_valid_q <= 1'b0;
    end else if (bus.flush) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        data_q <= mem[rd_ptr];
      end
    end
  end
`endif

  always_comb begin
    status             = '0;
    status.full        = (count == DEPTH_C);
    status.empty       = (count == '0);
    status.almostfull  = (count >= AF_C);
    status.almostempty = (count <= AE_C);
  end

  assign bus.data_out    = data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
  assign bus.ovf_sticky  = ovf_st;
  assign bus.udf_sticky  = udf_st;
  assign bus.count       = count;
  assign bus.full        = status.full;
  assign bus.empty       = status.empty;
  assign bus.almostfull  = status.almostfull;
  assign bus.almostempty = status.almostempty;

endmodule

// File: tb/tb_sync_fifo_gen2.sv
// tb/tb_sync_fifo_gen2.sv - directed scoreboard bench for sync_fifo_gen2 (DEPTH 8 and DEPTH 6 instances)
module tb_sync_fifo_gen2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_gen2_if #(.WIDTH(16), .DEPTH(8)) fa ();
  sync_fifo_gen2_if #(.WIDTH(16), .DEPTH(6)) fb ();

  sync_fifo_gen2 #(.WIDTH(16), .DEPTH(8)) dut_a (.clk(clk), .rst(rst), .bus(fa.slave));
  sync_fifo_gen2 #(.WIDTH(16), .DEPTH(6)) dut_b (.clk(clk), .rst(rst), .bus(fb.slave));

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares the DUT's read port with the scoreboard head and retires it.
  task automatic pop_cmp(input string tag, input bit sel_b);
    logic [15:0] e;
    if ((sel_b ? qb.size() : qa.size()) == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s_sb observed=empty_scoreboard expected=queued_word", tag);
      return;
    end
    e = sel_b ? qb.pop_front() : qa.pop_front();
    chk({tag, "_rv"},   sel_b ? fb.rd_valid : fa.rd_valid, 1);
    chk({tag, "_data"}, sel_b ? fb.data_out : fa.data_out, e);
  endtask

  task automatic write_a(input string tag, input logic [15:0] d);
    fa.wr_en = 1'b1; fa.data_in = d;
    step();
    fa.wr_en = 1'b0;
    chk({tag, "_wr_ack"}, fa.wr_ack, 1);
    qa.push_back(d);
  endtask

  task automatic read_a(input string tag);
`ifdef SYNC_FIFO_FWFT_EN
    pop_cmp(tag, 1'b0);
    fa.rd_en = 1'b1; step(); fa.rd_en = 1'b0;
`else
    fa.rd_en = 1'b1; step(); fa.rd_en = 1'b0;
    pop_cmp(tag, 1'b0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fa.flush = 0; fa.wr_en = 0; fa.rd_en = 0; fa.data_in = '0;
    fb.flush = 0; fb.wr_en = 0; fb.rd_en = 0; fb.data_in = '0;
    step(); step();

    chk("rst_count",   fa.count, 0);
    chk("rst_empty",   fa.empty, 1);
    chk("rst_ae",      fa.almostempty, 1);
    chk("rst_full",    fa.full, 0);
    chk("rst_af",      fa.almostfull, 0);
    chk("rst_dout",    fa.data_out, 0);
    chk("rst_rv",      fa.rd_valid, 0);
    chk("rst_sticky",  {fa.ovf_sticky, fa.udf_sticky, fa.overflow, fa.underflow, fa.wr_ack}, 0);
    rst = 1'b0;
    step();

    for (int i = 1; i <= 8; i++) begin
      write_a("fill", 16'(i));
      chk("fill_count", fa.count, i);
    end
    chk("fill_full", fa.full, 1);
    chk("fill_af",   fa.almostfull, 1);

    fa.wr_en = 1'b1; fa.data_in = 16'h0009;
    step();
    fa.wr_en = 1'b0;
    chk("ovf_pulse",  fa.overflow, 1);
    chk("ovf_noack",  fa.wr_ack, 0);
    chk("ovf_sticky", fa.ovf_sticky, 1);
    chk("ovf_count",  fa.count, 8);
    step();
    chk("ovf_clear",  fa.overflow, 0);
    chk("ovf_hold",   fa.ovf_sticky, 1);

    for (int i = 0; i < 8; i++) begin
      read_a("drain");
      chk("drain_count", fa.count, 7 - i);
    end
    chk("drain_empty", fa.empty, 1);

    fa.rd_en = 1'b1;
    step();
    fa.rd_en = 1'b0;
    chk("udf_pulse",  fa.underflow, 1);
    chk("udf_sticky", fa.udf_sticky, 1);
    chk("udf_empty",  fa.empty, 1);
    chk("udf_rv",     fa.rd_valid, 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("udf_dout",   fa.data_out, 0);
`else
    chk("udf_dout",   fa.data_out, 16'h0008);
`endif

    for (int i = 1; i <= 8; i++) write_a("refill", 16'h0100 + 16'(i));
    chk("refill_full", fa.full, 1);
`ifdef SYNC_FIFO_FWFT_EN
    pop_cmp("full_both", 1'b0);
`endif
    fa.wr_en = 1'b1; fa.rd_en = 1'b1; fa.data_in = 16'h0200;
    step();
    fa.wr_en = 1'b0; fa.rd_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    pop_cmp("full_both", 1'b0);
`endif
    qa.push_back(16'h0200);
    chk("full_both_ack",   fa.wr_ack, 1);
    chk("full_both_ovf",   fa.overflow, 0);
    chk("full_both_count", fa.count, 8);
    for (int i = 0; i < 8; i++) read_a("drain2");
    chk("drain2_count", fa.count, 0);

    fa.wr_en = 1'b1; fa.rd_en = 1'b1; fa.data_in = 16'h0300;
    step();
    fa.wr_en = 1'b0; fa.rd_en = 1'b0;
    qa.push_back(16'h0300);
    chk("empty_both_udf",   fa.underflow, 1);
    chk("empty_both_ack",   fa.wr_ack, 1);
    chk("empty_both_count", fa.count, 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("empty_both_rv",    fa.rd_valid, 1);
    chk("empty_both_dout",  fa.data_out, 16'h0300);
`else
    chk("empty_both_rv",    fa.rd_valid, 0);
`endif

    for (int i = 1; i <= 4; i++) write_a("pre_flush", 16'h0400 + 16'(i));
    chk("pre_flush_count",  fa.count, 5);
    chk("pre_flush_sticky", {fa.ovf_sticky, fa.udf_sticky}, 2'b11);
    fa.flush = 1'b1; fa.wr_en = 1'b1; fa.rd_en = 1'b1; fa.data_in = 16'h0BAD;
    step();
    fa.flush = 1'b0; fa.wr_en = 1'b0; fa.rd_en = 1'b0;
    qa.delete();
    chk("flush_count",  fa.count, 0);
    chk("flush_empty",  fa.empty, 1);
    chk("flush_sticky", {fa.ovf_sticky, fa.udf_sticky}, 0);
    chk("flush_pulses", {fa.wr_ack, fa.overflow, fa.underflow, fa.rd_valid}, 0);
    write_a("post_flush", 16'h0500);
    read_a("post_flush");

    fa.rd_en = 1'b1;
    step();
    fa.rd_en = 1'b0;
    chk("pre_rst_udf", fa.udf_sticky, 1);
    for (int i = 1; i <= 3; i++) write_a("burst", 16'h0700 + 16'(i));
    fa.wr_en = 1'b1; fa.rd_en = 1'b1; fa.data_in = 16'h07FF;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    qa.delete();
    chk("mid_rst_count",  fa.count, 0);
    chk("mid_rst_empty",  fa.empty, 1);
    chk("mid_rst_ae",     fa.almostempty, 1);
    chk("mid_rst_dout",   fa.data_out, 0);
    chk("mid_rst_flags",  {fa.rd_valid, fa.wr_ack, fa.overflow, fa.underflow, fa.udf_sticky, fa.ovf_sticky}, 0);
    fa.wr_en = 1'b0; fa.rd_en = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_count", fa.count, 0);

    write_a("abcd", 16'hABCD);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_rv",   fa.rd_valid, 1);
    chk("fwft_dout", fa.data_out, 16'hABCD);
`endif
    read_a("abcd");

    for (int i = 1; i <= 3; i++) begin
      fb.wr_en = 1'b1; fb.data_in = 16'h0600 + 16'(i);
      step();
      fb.wr_en = 1'b0;
      qb.push_back(16'h0600 + 16'(i));
    end
    chk("wrap_prime", fb.count, 3);
    for (int i = 4; i < 24; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      pop_cmp("wrap", 1'b1);
`endif
      fb.wr_en = 1'b1; fb.rd_en = 1'b1; fb.data_in = 16'h0600 + 16'(i);
      step();
      fb.wr_en = 1'b0; fb.rd_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      pop_cmp("wrap", 1'b1);
`endif
      qb.push_back(16'h0600 + 16'(i));
      chk("wrap_count", fb.count, 3);
      chk("wrap_ack",   fb.wr_ack, 1);
    end
    for (int i = 0; i < 3; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      pop_cmp("wrap_tail", 1'b1);
      fb.rd_en = 1'b1; step(); fb.rd_en = 1'b0;
`else
      fb.rd_en = 1'b1; step(); fb.rd_en = 1'b0;
      pop_cmp("wrap_tail", 1'b1);
`endif
    end
    chk("wrap_empty", fb.empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
